// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// The overflow threshold helper is only used when BIN2BCD_OVF_EN is defined.
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  // 10^n as a 64-bit constant, evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock behind valid/ready.
// Optional overflow saturation is enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_bin,
  output logic                in_ready,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
  output b2b_state_t          o_dbg_state
);

  // Handshake: a value is accepted on any rising edge where in_valid && in_ready;
  // in_ready is high exactly while IDLE. out_valid is a one-cycle pulse and
  // out_bcd/out_ovf hold until the next completion. Busy-time in_valid is ignored.

  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  b2b_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_acc;
  logic [BW-1:0]    r_out_bcd;
  logic             r_out_valid;
  logic [BW-1:0]    w_corr;
  logic [BW-1:0]    w_next_acc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit(r_acc[4*g +: 4]),
      .o_digit(w_corr[4*g +: 4])
    );
  end

  // Carry out of the top digit falls off here, giving in_bin mod 10^DIGITS.
  assign w_next_acc = {w_corr[BW-2:0], r_sr[WIDTH-1]};

`ifdef BIN2BCD_OVF_EN
  localparam logic [63:0] OVF_LIM = pow10(DIGITS);
  logic r_ovf_pend;
  logic r_out_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_acc       <= '0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
`ifdef BIN2BCD_OVF_EN
      r_ovf_pend  <= 1'b0;
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr    <= in_bin;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= SHIFT;
`ifdef BIN2BCD_OVF_EN
            r_ovf_pend <= (64'(in_bin) >= OVF_LIM);
`endif
          end
        end
        SHIFT: begin
          r_acc <= w_next_acc;
          r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b1;
`ifdef BIN2BCD_OVF_EN
            r_out_bcd   <= r_ovf_pend ? {DIGITS{4'h9}} : w_next_acc;
            r_out_ovf   <= r_ovf_pend;
`else
            r_out_bcd   <= w_next_acc;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out_bcd     = r_out_bcd;
  assign o_dbg_state = r_state;
`ifdef BIN2BCD_OVF_EN
  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed vector bench for bin2bcd_seq: conversions, back-to-back accepts, mid-run reset.
// Expectations follow BIN2BCD_OVF_EN when the macro is defined for the build.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 6;
  localparam int BW     = 4 * DIGITS;
  localparam int LAT    = 32;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    bcd;
    logic             ovf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_bin;
  logic             in_ready;
  logic             out_valid;
  logic [BW-1:0]    out_bcd;
  logic             out_ovf;
  b2b_state_t       dbg_state;

  int n_checks;
  int n_errors;
  logic [BW-1:0] exp_q[$];
  logic          ovf_q[$];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_bin(in_bin),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_bcd(out_bcd),
    .out_ovf(out_ovf),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one value for one edge, then wait for the result and score it.
  task automatic convert(input string name, input logic [WIDTH-1:0] v,
                         input logic [BW-1:0] exp_bcd, input logic exp_ovf,
                         input logic [BW-1:0] prev_bcd);
    int cycles;
    logic [BW-1:0] e;
    logic eo;
    exp_q.push_back(exp_bcd);
    ovf_q.push_back(exp_ovf);
    in_valid = 1'b1;
    in_bin   = v;
    tick();
    in_valid = 1'b0;
    in_bin   = $urandom_range(0, 1000);
    chk({name, "_busy"}, 32'(in_ready), 32'd0);
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 16) chk({name, "_hold"}, 32'(out_bcd), 32'(prev_bcd));
      if (out_valid) break;
    end
    chk({name, "_lat"}, cycles, LAT);
    e  = exp_q.pop_front();
    eo = ovf_q.pop_front();
    chk({name, "_bcd"}, 32'(out_bcd), 32'(e));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    chk({name, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[9];
    logic [BW-1:0] prev;
    int cycles;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bin   = '0;

    vecs[0] = '{32'd0,          24'h000000, 1'b0};
    vecs[1] = '{32'd123456,     24'h123456, 1'b0};
    vecs[2] = '{32'd999999,     24'h999999, 1'b0};
    vecs[3] = '{32'd9,          24'h000009, 1'b0};
    vecs[4] = '{32'd100000,     24'h100000, 1'b0};
    vecs[5] = '{32'd505050,     24'h505050, 1'b0};
`ifdef BIN2BCD_OVF_EN
    vecs[6] = '{32'd1000000,    24'h999999, 1'b1};
    vecs[7] = '{32'hFFFFFFFF,   24'h999999, 1'b1};
    vecs[8] = '{32'd1234567,    24'h999999, 1'b1};
`else
    vecs[6] = '{32'd1000000,    24'h000000, 1'b0};
    vecs[7] = '{32'hFFFFFFFF,   24'h967295, 1'b0};
    vecs[8] = '{32'd1234567,    24'h234567, 1'b0};
`endif

    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd",   32'(out_bcd), 32'd0);
    chk("rst_ovf",   32'(out_ovf), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    prev = '0;
    for (int i = 0; i < 9; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, prev);
      prev = vecs[i].bcd;
    end

    // Back-to-back: 42, then 7 accepted in the completion cycle, with noise while busy.
    convert("b2b_a", 32'd42, 24'h000042, 1'b0, prev);
    // convert() leaves us one cycle past completion; redo the pair precisely.
    exp_q.push_back(24'h000042);
    in_valid = 1'b1;
    in_bin   = 32'd42;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (out_valid) break;
    end
    chk("b2b1_lat", cycles, LAT);
    chk("b2b1_bcd", 32'(out_bcd), 32'(exp_q.pop_front()));
    chk("b2b1_rdy", 32'(in_ready), 32'd1);
    exp_q.push_back(24'h000007);
    in_valid = 1'b1;
    in_bin   = 32'd7;
    tick();
    in_valid = 1'b0;
    chk("b2b2_busy", 32'(in_ready), 32'd0);
    cycles = 0;
    while (cycles < 100) begin
      if (cycles == 5 || cycles == 11 || cycles == 20) begin
        in_valid = 1'b1;
        in_bin   = 32'd999;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cycles++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    chk("b2b2_lat", cycles, LAT);
    chk("b2b2_bcd", 32'(out_bcd), 32'(exp_q.pop_front()));
    tick();
    chk("b2b2_idle", 32'(in_ready), 32'd1);

    // Reset mid-conversion of 555555: no result, outputs back to reset values.
    in_valid = 1'b1;
    in_bin   = 32'd555555;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd",   32'(out_bcd), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_ovf",   32'(out_ovf), 32'd0);
    rst = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cycles++;
    end
    chk("abort_nopulse", cycles, 0);

    convert("post_rst", 32'd314159, 24'h314159, 1'b0, 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
